// File: rtl/uart_tx_frame_reg.sv
// UART transmit holding-and-framing register: a load captures D, builds the
// full serial frame and shifts it out LSB-first, one bit per baud tick.
module uart_tx_frame_reg #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] D,
    input  logic              shift,
    output logic [DATA_W-1:0] Q,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int FRAME_W = 1 + DATA_W + PARITY_EN + STOP_BITS;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam bit PAR_ODD = (PARITY_ODD != 0);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t             state;
    logic [FRAME_W-1:0] sr;
    logic [CNT_W-1:0]   cnt;
    logic [FRAME_W-1:0] frame_ld;

    // Stop bits come from the all-ones default; start bit sits in bit 0.
    always_comb begin
        frame_ld           = '1;
        frame_ld[0]        = 1'b0;
        frame_ld[DATA_W:1] = D;
        if (PARITY_EN != 0) begin
            frame_ld[DATA_W+1] = (^D) ^ PAR_ODD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            Q       <= '0;
            sr      <= '1;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            done    <= 1'b0;
            overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        Q     <= D;
                        sr    <= frame_ld;
                        cnt   <= CNT_W'(FRAME_W);
                        busy  <= 1'b1;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (load) begin
                        overrun <= 1'b1;
                    end
                    if (shift) begin
                        sr  <= {1'b1, sr[FRAME_W-1:1]};
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tx = sr[0];

endmodule

// File: doc/uart_tx_frame_reg.md
Name: uart_tx_frame_reg

Overview:
Parametrised UART transmit holding-and-framing register. A parallel load captures a data word into a readable holding register. The same load builds a complete serial frame: start bit, data LSB first, optional parity, and 1 or 2 stop bits. The frame is shifted out one bit per baud tick. The block sits between the TX data path and the baud-tick generator and drives the serial line directly.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9
PARITY_EN, 0, 1 inserts a parity bit after the data bits
PARITY_ODD, 0, 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
load  input  1  request to capture D and start a frame; single-cycle strobe
D  input  DATA_W  parallel data word
shift  input  1  baud tick; one-cycle pulse per bit time
Q  output  DATA_W  holding register, the last accepted word
tx  output  1  serial line; idles high
busy  output  1  high while a frame is in flight
done  output  1  one-cycle pulse when the final stop bit completes
overrun  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Frame width: FRAME_W = 1 + DATA_W + PARITY_EN + STOP_BITS.
- Internal state: frame shift register sr[FRAME_W-1:0] and a down-counter cnt of width clog2(FRAME_W+1).
- tx = sr[0]; it is a register bit, so it is glitch-free.
- Reset (reset=0, takes effect immediately, no clock needed): Q=0, sr=all ones, so tx=1; cnt=0, busy=0, done=0, overrun=0.
- Reset mid-frame: the frame is lost, tx returns to 1 at once, and done is not pulsed.
- Two states, derived from busy:
  - IDLE: busy=0.
  - SEND: busy=1.
- IDLE, load=1, at the clock edge:
  - Q<=D.
  - sr<={stop ones, parity, D, 1'b0}, with the start bit in sr[0].
  - cnt<=FRAME_W and busy<=1.
  - tx therefore goes to 0 (start bit) in the cycle after the load.
- IDLE, shift=1 without load: no effect; tx stays 1.
- IDLE, load and shift in the same cycle: the load is accepted and the shift is ignored.
- SEND, shift=1: sr<={1'b1, sr[FRAME_W-1:1]} and cnt<=cnt-1.
- SEND, the shift that moves cnt from 1 to 0: busy<=0, done<=1 for exactly one cycle, and tx is 1 afterwards.
- SEND, load=1: the load is rejected. Q and sr are unchanged and overrun pulses for one cycle. This also holds on the final shift cycle, because busy is still 1 at that edge.
- SEND, shift without load: the load-rejection path is not triggered.
- Parity:
  - Even parity = XOR of D.
  - Odd parity = the inverse of that.
  - Parity is computed from D at load time.
- Bit timing: the start bit lasts from the load until the first shift. Callers issue load in the cycle immediately after a shift tick to get a full start bit; the block does not enforce this.
- done and overrun are registered pulses; both are 0 in every other cycle.
- Q changes only on an accepted load or on reset.

Test Plan:
1. Reset: hold reset=0 while toggling load, shift and D -> tx=1, busy=0, Q=0, and done and overrun stay 0 throughout.
2. Defaults (DATA_W=8, no parity, 1 stop): load D=0xA5, then 10 shift pulses spaced 16 clocks apart -> Q=0xA5 and tx bit sequence 0,1,0,1,0,0,1,0,1,1. done pulses for one cycle on the 10th shift, busy falls with it, and tx stays 1 afterwards.
3. PARITY_EN=1, PARITY_ODD=0, D=0x07 -> 11-bit frame, parity bit 1. Repeat with PARITY_ODD=1 -> parity bit 0. D=0x00 with even parity -> parity bit 0.
4. Overrun: during the frame from test 2, load D=0x3C after the 3rd shift, and again in the same cycle as the 10th shift -> overrun pulses once for each attempt. Q stays 0xA5 and the tx sequence is unchanged.
5. Reset mid-frame: after the 4th shift, pulse reset=0 for 3 clocks -> tx=1 and busy=0 at once, and done is never pulsed. Then load D=0x5A -> a normal frame is sent and done pulses on the 10th shift.
6. STOP_BITS=2, DATA_W=7: load D=0x7F -> the frame takes 10 shifts, and tx is 1 for data bits 0-6 and both stop bits. done pulses on the 10th shift. An idle shift sent before the load has no effect.
